// File: rtl/lcd_power_seq_if.sv
// Control/status bundle between the LCD power sequencer and its surroundings.
// The slave side is the sequencer itself; the master side is top-level control plus the pins.
interface lcd_power_seq_if #(
    parameter int P_PWM_BITS = 8
);
    logic                  i_pwr_on;
    logic                  i_lcd_vs;
    logic [P_PWM_BITS-1:0] i_bl_duty;
    logic                  o_lcd_rst;
    logic                  o_timing_en;
    logic                  o_lcd_bl;
    logic                  o_ready;
    logic                  o_fault;
    logic [2:0]            o_state;

    modport master (
        output i_pwr_on, i_lcd_vs, i_bl_duty,
        input  o_lcd_rst, o_timing_en, o_lcd_bl, o_ready, o_fault, o_state
    );

    modport slave (
        input  i_pwr_on, i_lcd_vs, i_bl_duty,
        output o_lcd_rst, o_timing_en, o_lcd_bl, o_ready, o_fault, o_state
    );
endinterface

// File: rtl/lcd_power_seq.sv
// RGB LCD power-up/power-down sequencer on the pixel clock: panel reset, timing enable, backlight.
// Optional backlight PWM is enabled by defining LCD_BL_PWM_EN.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | panel off, waiting for power-on request
// RST_HOLD    | panel reset held low for P_RST_CYCLES pixel clocks
// INIT_WAIT   | reset released, panel self-init for P_INIT_CYCLES clocks
// FRAME_ON    | timing running, waiting P_FRAMES_ON vsync edges
// RUN         | backlight on, panel ready
// BL_OFF_WAIT | backlight off, waiting P_FRAMES_OFF vsync edges
module lcd_power_seq #(
    parameter logic [23:0] P_RST_CYCLES    = 24'd334,
    parameter logic [23:0] P_INIT_CYCLES   = 24'd666000,
    parameter logic [7:0]  P_FRAMES_ON     = 8'd4,
    parameter logic [7:0]  P_FRAMES_OFF    = 8'd2,
    parameter logic [23:0] P_FRAME_TIMEOUT = 24'd1000000,
    parameter int          P_PWM_BITS      = 8
) (
    input logic            i_lcd_pclk,
    input logic            i_rst,
    lcd_power_seq_if.slave bus
);
    // A zero delay or frame count behaves as one.
    localparam logic [23:0] RST_EFF  = (P_RST_CYCLES    == 24'd0) ? 24'd1 : P_RST_CYCLES;
    localparam logic [23:0] INIT_EFF = (P_INIT_CYCLES   == 24'd0) ? 24'd1 : P_INIT_CYCLES;
    localparam logic [23:0] TO_EFF   = (P_FRAME_TIMEOUT == 24'd0) ? 24'd1 : P_FRAME_TIMEOUT;
    localparam logic [7:0]  FON_EFF  = (P_FRAMES_ON     == 8'd0)  ? 8'd1  : P_FRAMES_ON;
    localparam logic [7:0]  FOFF_EFF = (P_FRAMES_OFF    == 8'd0)  ? 8'd1  : P_FRAMES_OFF;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RST_HOLD    = 3'd1,
        INIT_WAIT   = 3'd2,
        FRAME_ON    = 3'd3,
        RUN         = 3'd4,
        BL_OFF_WAIT = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [23:0] cyc_cnt, cyc_nxt;
    logic [7:0]  frm_cnt, frm_nxt;
    logic        fault_q, fault_nxt;
    logic        vs_prev, vs_edge;
    logic        lcd_rst_q, timing_en_q, lcd_bl_q, ready_q;
    logic        rst_nxt, ten_nxt, bl_gate_nxt, ready_nxt, bl_nxt;

    assign vs_edge = bus.i_lcd_vs & ~vs_prev;

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt + 24'd1;
        frm_nxt   = frm_cnt;
        fault_nxt = fault_q;
        case (state)
            IDLE: begin
                cyc_nxt = 24'd0;
                frm_nxt = 8'd0;
                if (bus.i_pwr_on) begin
                    state_nxt = RST_HOLD;
                    fault_nxt = 1'b0;
                end
            end
            RST_HOLD: begin
                if (!bus.i_pwr_on) begin
                    state_nxt = IDLE;
                end else if (cyc_cnt == RST_EFF - 24'd1) begin
                    state_nxt = INIT_WAIT;
                    cyc_nxt   = 24'd0;
                end
            end
            INIT_WAIT: begin
                if (!bus.i_pwr_on) begin
                    state_nxt = IDLE;
                end else if (cyc_cnt == INIT_EFF - 24'd1) begin
                    state_nxt = FRAME_ON;
                    cyc_nxt   = 24'd0;
                    frm_nxt   = 8'd0;
                end
            end
            FRAME_ON: begin
                if (!bus.i_pwr_on) begin
                    state_nxt = IDLE;
                end else if (vs_edge) begin
                    cyc_nxt = 24'd0;
                    if (frm_cnt == FON_EFF - 8'd1) state_nxt = RUN;
                    else                           frm_nxt   = frm_cnt + 8'd1;
                end else if (cyc_cnt == TO_EFF - 24'd1) begin
                    state_nxt = IDLE;
                    fault_nxt = 1'b1;
                end
            end
            RUN: begin
                cyc_nxt = 24'd0;
                if (!bus.i_pwr_on) begin
                    state_nxt = BL_OFF_WAIT;
                    frm_nxt   = 8'd0;
                end
            end
            BL_OFF_WAIT: begin
                // A renewed power-on request does not abort the power-down.
                if (vs_edge) begin
                    cyc_nxt = 24'd0;
                    if (frm_cnt == FOFF_EFF - 8'd1) state_nxt = IDLE;
                    else                            frm_nxt   = frm_cnt + 8'd1;
                end else if (cyc_cnt == TO_EFF - 24'd1) begin
                    state_nxt = IDLE;
                    fault_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cyc_nxt   = 24'd0;
                frm_nxt   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch together with o_state.
    always_comb begin
        rst_nxt     = (state_nxt != IDLE) && (state_nxt != RST_HOLD);
        ten_nxt     = (state_nxt == FRAME_ON) || (state_nxt == RUN) || (state_nxt == BL_OFF_WAIT);
        bl_gate_nxt = (state_nxt == RUN);
        ready_nxt   = (state_nxt == RUN);
    end

`ifdef LCD_BL_PWM_EN
    logic [P_PWM_BITS-1:0] pwm_cnt, pwm_cnt_nxt, duty_q, duty_nxt;

    // Duty is only picked up at the period boundary so a period is never truncated.
    always_comb begin
        pwm_cnt_nxt = pwm_cnt + P_PWM_BITS'(1);
        duty_nxt    = (pwm_cnt_nxt == '0) ? bus.i_bl_duty : duty_q;
        bl_nxt      = bl_gate_nxt & (pwm_cnt_nxt < duty_nxt);
    end

    always_ff @(posedge i_lcd_pclk) begin
        if (i_rst) begin
            pwm_cnt <= '0;
            duty_q  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt_nxt;
            duty_q  <= duty_nxt;
        end
    end
`else
    logic unused_duty;
    assign unused_duty = ^bus.i_bl_duty;
    assign bl_nxt      = bl_gate_nxt;
`endif

    always_ff @(posedge i_lcd_pclk) begin
        if (i_rst) begin
            state       <= IDLE;
            cyc_cnt     <= 24'd0;
            frm_cnt     <= 8'd0;
            fault_q     <= 1'b0;
            vs_prev     <= 1'b0;
            lcd_rst_q   <= 1'b0;
            timing_en_q <= 1'b0;
            lcd_bl_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cyc_cnt     <= cyc_nxt;
            frm_cnt     <= frm_nxt;
            fault_q     <= fault_nxt;
            vs_prev     <= bus.i_lcd_vs;
            lcd_rst_q   <= rst_nxt;
            timing_en_q <= ten_nxt;
            lcd_bl_q    <= bl_nxt;
            ready_q     <= ready_nxt;
        end
    end

    assign bus.o_lcd_rst   = lcd_rst_q;
    assign bus.o_timing_en = timing_en_q;
    assign bus.o_lcd_bl    = lcd_bl_q;
    assign bus.o_ready     = ready_q;
    assign bus.o_fault     = fault_q;
    assign bus.o_state     = state;
endmodule

// File: tb/tb_lcd_power_seq.sv
// Self-checking bench for lcd_power_seq: per-cycle expected outputs go through a scoreboard queue.
// Define LCD_BL_PWM_EN for both RTL and bench to exercise the backlight PWM.
module tb_lcd_power_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    typedef struct {
        string      tag;
        logic [7:0] word;
        logic [7:0] mask;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    lcd_power_seq_if #(.P_PWM_BITS(4)) ifc ();

    lcd_power_seq #(
        .P_RST_CYCLES   (24'd4),
        .P_INIT_CYCLES  (24'd6),
        .P_FRAMES_ON    (8'd2),
        .P_FRAMES_OFF   (8'd2),
        .P_FRAME_TIMEOUT(24'd50),
        .P_PWM_BITS     (4)
    ) dut (
        .i_lcd_pclk(clk),
        .i_rst     (rst),
        .bus       (ifc.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // {state, lcd_rst, timing_en, bl, ready, fault} as the panel table dictates
    function automatic logic [7:0] exp_word(input logic [2:0] st, input logic flt);
        logic r, t, b, rdy;
        r   = (st >= 3'd2) && (st <= 3'd5);
        t   = (st == 3'd3) || (st == 3'd4) || (st == 3'd5);
        b   = (st == 3'd4);
        rdy = (st == 3'd4);
        return {st, r, t, b, rdy, flt};
    endfunction

    task automatic step(input string tag, input logic r, input logic pwr, input logic vs,
                        input logic [2:0] st, input logic flt);
        exp_t e;
        logic [7:0] obs;
        rst          = r;
        ifc.i_pwr_on = pwr;
        ifc.i_lcd_vs = vs;
        e.tag  = tag;
        e.word = exp_word(st, flt);
        e.mask = 8'hFF;
`ifdef LCD_BL_PWM_EN
        if (st == 3'd4) e.mask = 8'hFB;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        obs = {ifc.o_state, ifc.o_lcd_rst, ifc.o_timing_en, ifc.o_lcd_bl, ifc.o_ready, ifc.o_fault};
        e = sb.pop_front();
        chk(e.tag, 32'(obs & e.mask), 32'(e.word & e.mask));
    endtask

    // From IDLE (vsync low) through to RUN.
    task automatic power_up(input string tag);
        repeat (4) step({tag, "_rsthold"}, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
        repeat (6) step({tag, "_init"},    1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        step({tag, "_frame_on"}, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0);
        step({tag, "_vs1"},      1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
        step({tag, "_gap"},      1'b0, 1'b1, 1'b0, 3'd3, 1'b0);
        step({tag, "_vs2_run"},  1'b0, 1'b1, 1'b1, 3'd4, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        ifc.i_pwr_on  = 1'b0;
        ifc.i_lcd_vs  = 1'b0;
        ifc.i_bl_duty = 4'd0;

        repeat (3) step("reset", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step("idle", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Normal power-up then power-down
        power_up("up");
        repeat (3) step("run_hold", 1'b0, 1'b1, 1'b0, 3'd4, 1'b0);
        step("bl_off",   1'b0, 1'b0, 1'b0, 3'd5, 1'b0);
        step("off_wait", 1'b0, 1'b0, 1'b0, 3'd5, 1'b0);
        step("off_vs1",  1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
        step("off_gap",  1'b0, 1'b0, 1'b0, 3'd5, 1'b0);
        step("off_done", 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        step("off_idle", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Abort during INIT_WAIT
        repeat (4) step("ab_rsthold", 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
        repeat (3) step("ab_init",    1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        step("abort_idle", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        repeat (2) step("abort_stay", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Vsync never arrives: timeout after 50 cycles in FRAME_ON
        repeat (4) step("to_rsthold", 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
        repeat (6) step("to_init",    1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        repeat (50) step("to_frame_on", 1'b0, 1'b1, 1'b0, 3'd3, 1'b0);
        step("timeout_fault", 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
        step("fault_clear",   1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
        step("rsthold_cont",  1'b0, 1'b1, 1'b0, 3'd1, 1'b0);

        // Synchronous reset mid-sequence
        step("rst_mid", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step("rst_idle", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Power-on reasserted during BL_OFF_WAIT: power-down completes, then restart
        power_up("re");
        step("re_bl_off",  1'b0, 1'b0, 1'b0, 3'd5, 1'b0);
        step("re_reassert", 1'b0, 1'b1, 1'b0, 3'd5, 1'b0);
        step("re_vs1",     1'b0, 1'b1, 1'b1, 3'd5, 1'b0);
        step("re_gap",     1'b0, 1'b1, 1'b0, 3'd5, 1'b0);
        step("re_idle",    1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        step("re_restart", 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
        step("re_rst",     1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

`ifdef LCD_BL_PWM_EN
        begin
            int hi;
            ifc.i_bl_duty = 4'd4;
            step("pwm_idle", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
            power_up("pwm");
            repeat (20) step("pwm_settle", 1'b0, 1'b1, 1'b0, 3'd4, 1'b0);
            hi = 0;
            for (int i = 0; i < 16; i++) begin
                step("pwm_run4", 1'b0, 1'b1, 1'b0, 3'd4, 1'b0);
                hi += int'(ifc.o_lcd_bl);
            end
            chk("pwm_duty4_high", 32'(hi), 32'd4);
            ifc.i_bl_duty = 4'd0;
            repeat (32) step("pwm_settle0", 1'b0, 1'b1, 1'b0, 3'd4, 1'b0);
            hi = 0;
            for (int i = 0; i < 16; i++) begin
                step("pwm_run0", 1'b0, 1'b1, 1'b0, 3'd4, 1'b0);
                hi += int'(ifc.o_lcd_bl);
            end
            chk("pwm_duty0_high", 32'(hi), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
